// File: rtl/bus_fifo_pkg.sv
// Register map constants and field positions for the bus event FIFO peripheral.
package bus_fifo_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_CLEAR  = 3'd4;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UDF   = 3;
    localparam int ST_IRQ   = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_THR_LSB = 8;

    localparam int CLR_FLUSH = 0;
    localparam int CLR_OVF   = 1;
    localparam int CLR_UDF   = 2;

    typedef struct packed {
        logic [7:0] thr;
        logic       irq_en;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/bus_fifo_slave_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers, occupancy count and flush.
// Caller guarantees push only when not full and pop only when not empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates what is ever read out.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/bus_fifo_slave.sv
// Memory-mapped event FIFO: producers push words, the CPU pops them via DATA reads.
// Every bus request gets a registered single-cycle response; irq is a registered level.
module bus_fifo_slave
    import bus_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic        m_write,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic        m_ready,
    output logic [31:0] m_rdata,
    output logic        m_rvalid,
    input  logic        evt_valid,
    input  logic [31:0] evt_data,
    output logic        evt_ready,
    output logic        irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ctrl_t       ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        irq_q, irq_d;
    logic        ready_q, ready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]       idx;
    logic             bus_wr, bus_rd, clr_hit;
    logic             push, pop, flush, ovf_set, udf_set;
    logic [31:0]      status, cnt_ext, thr_ext;
    logic [31:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count, fifo_count_nxt;
    logic             fifo_full, fifo_empty;
    logic             unused_ok;

    sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (evt_data),
        .rdata     (fifo_rdata),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Depends only on flops, so the producer never sees a path from the bus.
    assign evt_ready = ctrl_q.en && !fifo_full;

    always_comb begin
        idx     = m_addr[4:2];
        bus_wr  = m_valid && m_write;
        bus_rd  = m_valid && !m_write;
        clr_hit = bus_wr && (idx == REG_CLEAR) && m_wstrb[0];
        flush   = clr_hit && m_wdata[CLR_FLUSH];
        pop     = bus_rd && (idx == REG_DATA) && !fifo_empty;
        udf_set = bus_rd && (idx == REG_DATA) && fifo_empty;
        push    = evt_valid && evt_ready && !flush;
        ovf_set = evt_valid && ctrl_q.en && fifo_full && !flush;

        ctrl_d = ctrl_q;
        if (bus_wr && (idx == REG_CTRL)) begin
            if (m_wstrb[0]) begin
                ctrl_d.en     = m_wdata[CTRL_EN];
                ctrl_d.irq_en = m_wdata[CTRL_IRQ_EN];
            end
            if (m_wstrb[1]) ctrl_d.thr = m_wdata[CTRL_THR_LSB +: 8];
        end

        ovf_d = ovf_set || (ovf_q && !(clr_hit && m_wdata[CLR_OVF]));
        udf_d = udf_set || (udf_q && !(clr_hit && m_wdata[CLR_UDF]));

        status           = '0;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVF]   = ovf_q;
        status[ST_UDF]   = udf_q;
        status[ST_IRQ]   = irq_q;

        rdata_d = '0;
        if (bus_rd) begin
            case (idx)
                REG_DATA:   rdata_d = fifo_empty ? 32'h0 : fifo_rdata;
                REG_STATUS: rdata_d = status;
                REG_COUNT:  rdata_d = 32'(fifo_count);
                REG_CTRL:   rdata_d = {16'h0, ctrl_q.thr, 6'h0, ctrl_q.irq_en, ctrl_q.en};
                default:    rdata_d = '0;
            endcase
        end
        ready_d  = bus_wr;
        rvalid_d = bus_rd;

        // Count never exceeds DEPTH, so a threshold above DEPTH can never fire.
        cnt_ext = 32'(fifo_count_nxt);
        thr_ext = 32'(ctrl_d.thr);
        irq_d   = ctrl_d.irq_en && (((thr_ext != 0) && (cnt_ext >= thr_ext)) || ovf_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_q    <= 1'b0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            irq_q    <= irq_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign m_ready  = ready_q;
    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;
    assign irq      = irq_q;

    assign unused_ok = ^{m_addr[31:5], m_addr[1:0], m_wdata[31:16], m_wdata[7:3], m_wstrb[3:2]};

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Directed bench for bus_fifo_slave: register vector table plus FIFO corner sequences.
module tb_bus_fifo_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, m_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready, m_rvalid;
    logic [31:0] m_rdata;
    logic        evt_valid;
    logic [31:0] evt_data;
    logic        evt_ready, irq;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_DATA = 32'h00, A_STATUS = 32'h04, A_COUNT = 32'h08,
                            A_CTRL = 32'h0C, A_CLEAR = 32'h10;

    bus_fifo_slave #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_cycle(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb);
        m_valid = 1'b1; m_write = wr; m_addr = addr; m_wdata = wdata; m_wstrb = strb;
        @(posedge clk); #1;
        m_valid = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    endtask

    task automatic rd_reg(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus_cycle(1'b0, addr, 32'h0, 4'h0);
        check({name, "_rvalid"}, 32'(m_rvalid), 32'h1);
        check(name, m_rdata, exp);
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input string name);
        bus_cycle(1'b1, addr, data, strb);
        check({name, "_ready"}, 32'(m_ready), 32'h1);
    endtask

    task automatic push(input logic [31:0] data);
        evt_valid = 1'b1; evt_data = data;
        @(posedge clk); #1;
        evt_valid = 1'b0;
    endtask

    vec_t        vecs[17];
    logic [31:0] exp5[5];

    initial begin
        rst = 1'b1;
        m_valid = 0; m_write = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
        evt_valid = 0; evt_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(m_ready), 0);
        check("rst_rvalid", 32'(m_rvalid), 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_evt_ready", 32'(evt_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0]  = mk(0, A_STATUS, 0, 4'h0, 32'h1, "status_after_reset");
        vecs[1]  = mk(0, A_COUNT, 0, 4'h0, 32'h0, "count_after_reset");
        vecs[2]  = mk(1, A_CTRL, 32'hFFFF_FFFF, 4'b0010, 0, "ctrl_wr_lane1");
        vecs[3]  = mk(0, A_CTRL, 0, 4'h0, 32'h0000_FF00, "ctrl_rd_lane1");
        vecs[4]  = mk(0, 32'h1C, 0, 4'h0, 32'h0, "unmapped_rd");
        vecs[5]  = mk(1, A_CTRL, 32'h0000_0401, 4'hF, 0, "ctrl_wr_401");
        vecs[6]  = mk(0, A_CTRL, 0, 4'h0, 32'h0000_0401, "ctrl_rd_401");
        vecs[7]  = mk(1, A_STATUS, 32'hFFFF_FFFF, 4'hF, 0, "status_wr_ignored");
        vecs[8]  = mk(0, A_STATUS, 0, 4'h0, 32'h1, "status_after_wr");
        vecs[9]  = mk(0, A_CLEAR, 0, 4'h0, 32'h0, "clear_rd_zero");
        vecs[10] = mk(1, 32'h14, 32'hFFFF_FFFF, 4'hF, 0, "unmapped_wr");
        vecs[11] = mk(0, A_DATA, 0, 4'h0, 32'h0, "data_rd_empty");
        vecs[12] = mk(0, A_STATUS, 0, 4'h0, 32'h9, "status_udf");
        vecs[13] = mk(1, A_CLEAR, 32'h4, 4'h0, 0, "clear_no_strb");
        vecs[14] = mk(0, A_STATUS, 0, 4'h0, 32'h9, "status_udf_kept");
        vecs[15] = mk(1, A_CLEAR, 32'h4, 4'h1, 0, "clear_udf");
        vecs[16] = mk(0, A_STATUS, 0, 4'h0, 32'h1, "status_udf_cleared");

        for (int i = 0; i < 17; i++) begin
            m_valid = 1'b1; m_write = vecs[i].wr; m_addr = vecs[i].addr;
            m_wdata = vecs[i].wdata; m_wstrb = vecs[i].strb;
            @(posedge clk); #1;
            check({vecs[i].name, "_ready"}, 32'(m_ready), 32'(vecs[i].wr));
            check({vecs[i].name, "_rvalid"}, 32'(m_rvalid), 32'(!vecs[i].wr));
            check(vecs[i].name, m_rdata, vecs[i].wr ? 32'h0 : vecs[i].exp);
        end
        m_valid = 0; m_write = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
        @(posedge clk); #1;
        check("idle_ready", 32'(m_ready), 0);
        check("idle_rvalid", 32'(m_rvalid), 0);
        check("idle_rdata", m_rdata, 0);

        // In-order readout, back-to-back DATA reads, then underflow.
        check("evt_ready_enabled", 32'(evt_ready), 1);
        push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
        exp5[0] = 32'hA1; exp5[1] = 32'hA2; exp5[2] = 32'hA3; exp5[3] = 32'hA4; exp5[4] = 32'h0;
        m_valid = 1'b1; m_write = 1'b0; m_addr = A_DATA;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_rvalid%0d", k), 32'(m_rvalid), 1);
            check($sformatf("b2b_data%0d", k), m_rdata, exp5[k]);
        end
        m_valid = 1'b0;
        rd_reg(A_STATUS, 32'h9, "status_empty_udf");
        wr_reg(A_CLEAR, 32'h4, 4'h1, "clear_udf2");

        // Overflow at DEPTH.
        evt_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            evt_data = 32'h100 + 32'(i);
            check($sformatf("fill_evt_ready%0d", i), 32'(evt_ready), (i < 16) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        evt_valid = 1'b0;
        check("full_evt_ready", 32'(evt_ready), 0);
        rd_reg(A_STATUS, 32'h6, "status_full_ovf");
        rd_reg(A_COUNT, 32'd16, "count_full");
        check("irq_disabled", 32'(irq), 0);
        wr_reg(A_CLEAR, 32'h3, 4'h1, "clear_flush_ovf");
        rd_reg(A_STATUS, 32'h1, "status_after_flush");
        rd_reg(A_COUNT, 32'h0, "count_after_flush");

        // Threshold interrupt.
        wr_reg(A_CTRL, 32'h0000_0303, 4'hF, "ctrl_303");
        push(32'hB1); push(32'hB2);
        check("irq_below_thr", 32'(irq), 0);
        push(32'hB3);
        check("irq_at_thr", 32'(irq), 1);
        rd_reg(A_DATA, 32'hB1, "data_b1");
        check("irq_after_pop", 32'(irq), 0);

        // Simultaneous push and pop keep count.
        push(32'hC1); push(32'hC2); push(32'hC3);
        evt_valid = 1'b1; evt_data = 32'hC4;
        rd_reg(A_DATA, 32'hB2, "data_pushpop");
        evt_valid = 1'b0;
        rd_reg(A_COUNT, 32'd5, "count_pushpop");

        // Flush wins over a same-edge push.
        evt_valid = 1'b1; evt_data = 32'hD1;
        wr_reg(A_CLEAR, 32'h1, 4'h1, "flush_with_push");
        evt_valid = 1'b0;
        rd_reg(A_COUNT, 32'h0, "count_flush_push");
        rd_reg(A_STATUS, 32'h1, "status_flush_push");

        // Full plus pop: push refused and OVF set; irq follows OVF.
        for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
        evt_valid = 1'b1; evt_data = 32'hEE;
        rd_reg(A_DATA, 32'h200, "data_full_pop");
        evt_valid = 1'b0;
        rd_reg(A_COUNT, 32'd15, "count_full_pop");
        rd_reg(A_STATUS, 32'h14, "status_full_pop");
        wr_reg(A_CLEAR, 32'h7, 4'h1, "clear_all");
        rd_reg(A_STATUS, 32'h1, "status_clear_all");

        // OVF set and clear on the same edge: set wins.
        wr_reg(A_CTRL, 32'h1, 4'hF, "ctrl_en_only");
        for (int i = 0; i < 16; i++) push(32'h300 + 32'(i));
        evt_valid = 1'b1; evt_data = 32'hEF;
        wr_reg(A_CLEAR, 32'h2, 4'h1, "ovf_set_clr");
        evt_valid = 1'b0;
        rd_reg(A_STATUS, 32'h6, "status_set_wins");
        wr_reg(A_CLEAR, 32'h7, 4'h1, "clear_all2");

        // Disabled: pushes dropped silently.
        wr_reg(A_CTRL, 32'h0, 4'hF, "ctrl_off");
        check("evt_ready_disabled", 32'(evt_ready), 0);
        push(32'hF1);
        rd_reg(A_STATUS, 32'h1, "status_disabled_push");
        rd_reg(A_COUNT, 32'h0, "count_disabled_push");

        // Reset in the middle of a DATA read.
        wr_reg(A_CTRL, 32'h1, 4'hF, "ctrl_en_rst");
        push(32'h77);
        m_valid = 1'b1; m_write = 1'b0; m_addr = A_DATA;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
        check("rst_mid_rvalid", 32'(m_rvalid), 0);
        check("rst_mid_rdata", m_rdata, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rvalid", 32'(m_rvalid), 0);
        check("post_rst_evt_ready", 32'(evt_ready), 0);
        rd_reg(A_STATUS, 32'h1, "status_post_rst");
        rd_reg(A_COUNT, 32'h0, "count_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
